// File: rtl/outfifo_async_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : outfifo_async_pkg
// Description : Pointer width and Gray-code helpers for outfifo_async.
// Revision    : 1.0 - initial release
// ============================================================================
package outfifo_async_pkg;

    // The widest pointer needed (DEPTH up to 256). Helpers work at this width.
    localparam int c_PTR_MAX_W = 9;

    typedef logic [c_PTR_MAX_W-1:0] ptr_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[c_PTR_MAX_W-1] = g[c_PTR_MAX_W-1];
        for (int i = c_PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/outfifo_gray_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : outfifo_gray_sync
// Description : Two-flop synchronizer, async active-low clear, parameterized width.
// Revision    : 1.0 - initial release
// ============================================================================
module outfifo_gray_sync
    import outfifo_async_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/outfifo_async.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : outfifo_async
// Description : Dual-clock FWFT FIFO, Gray pointers; o_fill with OUTFIFO_ASYNC_FILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module outfifo_async
    import outfifo_async_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  i_aclk,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    input  logic                  i_rd,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty
`ifdef OUTFIFO_ASYNC_FILL_EN
    ,
    output logic [$clog2(DEPTH):0] o_fill
`endif
);

    localparam int c_PTR_W  = ptr_width(DEPTH);
    localparam int c_ADDR_W = c_PTR_W - 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [c_PTR_W-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [c_PTR_W-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [c_PTR_W-1:0] rgray_s;
    logic [c_PTR_W-1:0] wgray_s;
    logic               full_q, full_d, empty_q, empty_d;
    logic               wr_en, rd_en;
    logic               arst_n;

    // ---------------- write domain ----------------
    assign wr_en   = i_wr & ~full_q;
    assign wbin_d  = wbin_q + c_PTR_W'(wr_en);
    assign wgray_d = c_PTR_W'(bin2gray(ptr_t'(wbin_d)));
    assign full_d  = (wgray_d == {~rgray_s[c_PTR_W-1 -: 2], rgray_s[c_PTR_W-3:0]});

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge s_clk) begin
        if (wr_en) begin
            mem_q[wbin_q[c_ADDR_W-1:0]] <= i_wr_data;
        end
    end

    outfifo_gray_sync #(.WIDTH(c_PTR_W)) u_rptr_sync (
        .clk_i  (s_clk),
        .rst_ni (s_rst),
        .d_i    (rgray_q),
        .q_o    (rgray_s)
    );

    // ---------------- read domain ----------------
    // Reset asserts asynchronously but releases only after two i_aclk edges.
    outfifo_gray_sync #(.WIDTH(1)) u_rst_sync (
        .clk_i  (i_aclk),
        .rst_ni (s_rst),
        .d_i    (1'b1),
        .q_o    (arst_n)
    );

    outfifo_gray_sync #(.WIDTH(c_PTR_W)) u_wptr_sync (
        .clk_i  (i_aclk),
        .rst_ni (arst_n),
        .d_i    (wgray_q),
        .q_o    (wgray_s)
    );

    assign rd_en   = i_rd & ~empty_q;
    assign rbin_d  = rbin_q + c_PTR_W'(rd_en);
    assign rgray_d = c_PTR_W'(bin2gray(ptr_t'(rbin_d)));
    assign empty_d = (rgray_d == wgray_s);

    always_ff @(posedge i_aclk or negedge arst_n) begin
        if (!arst_n) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
        end
    end

    assign o_full    = full_q;
    assign o_empty   = empty_q;
    assign o_rd_data = mem_q[rbin_q[c_ADDR_W-1:0]];

`ifdef OUTFIFO_ASYNC_FILL_EN
    logic [c_PTR_W-1:0] rbin_s;
    logic [c_PTR_W-1:0] fill_q;

    // Modulo-2*DEPTH subtraction yields 0..DEPTH directly.
    assign rbin_s = c_PTR_W'(gray2bin(ptr_t'(rgray_s)));

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= wbin_d - rbin_s;
        end
    end

    assign o_fill = fill_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_outfifo_async.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_outfifo_async
// Description : Directed self-checking bench for outfifo_async (DEPTH=16, 100/250 MHz).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outfifo_async;

    logic       s_clk     = 1'b0;
    logic       i_aclk    = 1'b0;
    logic       s_rst     = 1'b0;
    logic       i_wr      = 1'b0;
    logic       i_rd      = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       o_full;
    logic       o_empty;
    logic [7:0] o_rd_data;
`ifdef OUTFIFO_ASYNC_FILL_EN
    logic [4:0] o_fill;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    outfifo_async #(.DEPTH(16), .DATA_WIDTH(8)) dut (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .i_aclk    (i_aclk),
        .i_wr      (i_wr),
        .i_wr_data (i_wr_data),
        .o_full    (o_full),
        .i_rd      (i_rd),
        .o_rd_data (o_rd_data),
        .o_empty   (o_empty)
`ifdef OUTFIFO_ASYNC_FILL_EN
        ,
        .o_fill    (o_fill)
`endif
    );

    always #5 s_clk = ~s_clk;
    initial begin
        #0.7;
        forever #2 i_aclk = ~i_aclk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wr_one(input logic [7:0] d);
        @(posedge s_clk); #1;
        i_wr      = 1'b1;
        i_wr_data = d;
        @(posedge s_clk); #1;
        i_wr      = 1'b0;
    endtask

    task automatic rd_one(output logic [7:0] d);
        int n;
        n = 0;
        @(posedge i_aclk); #0.5;
        while (o_empty && n < 50) begin
            @(posedge i_aclk); #0.5;
            n++;
        end
        chk("rd_avail", 32'(!o_empty), 32'd1);
        d    = o_rd_data;
        i_rd = 1'b1;
        @(posedge i_aclk); #0.5;
        i_rd = 1'b0;
    endtask

    logic [7:0] rx;
    logic [7:0] exp_b;
    logic [7:0] rx_q [$];
    int         k;
    int         wcnt, rcnt, wguard, rguard;

    initial begin
        // ---- reset state ----
        #23;
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
`ifdef OUTFIFO_ASYNC_FILL_EN
        chk("rst_fill",  32'(o_fill),  32'd0);
`endif
        @(negedge s_clk);
        s_rst = 1'b1;
        repeat (5) @(posedge s_clk);
        #1;

        // ---- single-word latency ----
        i_wr      = 1'b1;
        i_wr_data = 8'hA5;
        @(posedge s_clk);
        fork
            begin
                #1 i_wr = 1'b0;
            end
            begin
                k = 0;
                while (o_empty && k < 8) begin
                    @(posedge i_aclk); #0.3;
                    k++;
                end
            end
        join
        chk("lat_edges_2to3", 32'(k >= 2 && k <= 3), 32'd1);
        chk("lat_data", 32'(o_rd_data), 32'hA5);
        rd_one(rx);
        chk("lat_pop", 32'(rx), 32'hA5);
        chk("lat_empty_after_pop", 32'(o_empty), 32'd1);

        // ---- fill to full, drop overflow ----
        repeat (4) @(posedge s_clk);
        #1;
        i_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'(i);
            @(posedge s_clk); #1;
            chk($sformatf("fill_full_%0d", i), 32'(o_full), 32'(i == 15));
        end
        i_wr_data = 8'hFF;
        @(posedge s_clk); #1;
        i_wr = 1'b0;
        chk("full_after_drop", 32'(o_full), 32'd1);
`ifdef OUTFIFO_ASYNC_FILL_EN
        chk("fill_at_full", 32'(o_fill), 32'd16);
`endif
        k = 0;
        @(posedge i_aclk); #0.5;
        while (o_empty && k < 20) begin
            @(posedge i_aclk); #0.5;
            k++;
        end
        i_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(o_rd_data), 32'(i));
            @(posedge i_aclk); #0.5;
        end
        i_rd = 1'b0;
        chk("drain_empty", 32'(o_empty), 32'd1);
        repeat (4) @(posedge s_clk);
        #1;
        chk("drain_full_clear", 32'(o_full), 32'd0);

        // ---- rd held high while empty, then data arrives ----
        @(posedge i_aclk); #0.5;
        i_rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_aclk); #0.5;
            chk("rd_while_empty", 32'(o_empty), 32'd1);
        end
        rx_q.delete();
        fork
            begin
                wr_one(8'h31);
                wr_one(8'h32);
                wr_one(8'h33);
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    if (!o_empty) rx_q.push_back(o_rd_data);
                    @(posedge i_aclk); #0.5;
                end
            end
        join
        i_rd = 1'b0;
        chk("bnd_count", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("bnd_data_%0d", i), 32'(rx_q[i]), 32'(8'h31 + 8'(i)));
            end
        end

        // ---- streaming with random gaps ----
        wcnt = 0; rcnt = 0; wguard = 0; rguard = 0;
        fork
            begin
                @(posedge s_clk); #1;
                while (wcnt < 1000 && wguard < 20000) begin
                    wguard++;
                    if (!o_full && $urandom_range(0, 3) != 0) begin
                        i_wr      = 1'b1;
                        i_wr_data = wcnt[7:0];
                        wcnt++;
                    end else begin
                        i_wr = 1'b0;
                    end
                    @(posedge s_clk); #1;
                end
                i_wr = 1'b0;
            end
            begin
                @(posedge i_aclk); #0.5;
                while (rcnt < 1000 && rguard < 40000) begin
                    rguard++;
                    if (!o_empty && $urandom_range(0, 5) == 0) begin
                        i_rd  = 1'b1;
                        exp_b = rcnt[7:0];
                        chk("stream_data", 32'(o_rd_data), 32'(exp_b));
                        rcnt++;
                    end else begin
                        i_rd = 1'b0;
                    end
                    @(posedge i_aclk); #0.5;
                end
                i_rd = 1'b0;
            end
        join
        chk("stream_count", 32'(rcnt), 32'd1000);
        repeat (5) @(posedge i_aclk);
        #0.5;
        chk("stream_empty", 32'(o_empty), 32'd1);

        // ---- reset mid-stream ----
        @(posedge s_clk); #1;
        i_wr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'h80 + 8'(i);
            @(posedge s_clk); #1;
        end
        i_wr = 1'b0;
        chk("pre_rst_full", 32'(o_full), 32'd1);
        s_rst = 1'b0;
        #0.5;
        chk("mid_rst_empty", 32'(o_empty), 32'd1);
        chk("mid_rst_full",  32'(o_full),  32'd0);
`ifdef OUTFIFO_ASYNC_FILL_EN
        chk("mid_rst_fill",  32'(o_fill),  32'd0);
`endif
        #20;
        @(negedge s_clk);
        s_rst = 1'b1;
        repeat (2) @(posedge s_clk);
        wr_one(8'h5A);
        rd_one(rx);
        chk("post_rst_first", 32'(rx), 32'h5A);
        chk("post_rst_empty", 32'(o_empty), 32'd1);

`ifdef OUTFIFO_ASYNC_FILL_EN
        // ---- fill count ----
        repeat (4) @(posedge s_clk);
        for (int i = 0; i < 5; i++) wr_one(8'h40 + 8'(i));
        chk("fill_5", 32'(o_fill), 32'd5);
        rd_one(rx);
        rd_one(rx);
        repeat (3) @(posedge s_clk);
        #1;
        chk("fill_3", 32'(o_fill), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/outfifo_async.md
OUTFIFO_ASYNC -- requirements
Module: outfifo_async

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, 4..256.
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 s_clk  input  1  processor (write-side) clock.
REQ-004 s_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_aclk  input  1  consumer (read-side) clock, asynchronous to s_clk.
REQ-006 i_wr  input  1  write strobe, s_clk domain.
REQ-007 i_wr_data  input  DATA_WIDTH  write word, s_clk domain.
REQ-008 o_full  output  1  FIFO full, s_clk domain.
REQ-009 i_rd  input  1  read/pop strobe, i_aclk domain.
REQ-010 o_rd_data  output  DATA_WIDTH  head word, first-word-fall-through, i_aclk domain.
REQ-011 o_empty  output  1  FIFO empty, i_aclk domain.
REQ-012 o_fill  output  log2(DEPTH)+1  entry count seen by the write side, s_clk domain; present only when the Configuration macro is defined.

Function
REQ-013 Storage SHALL be a DEPTH x DATA_WIDTH dual-clock memory: written on s_clk, read asynchronously by address on the i_aclk side.
REQ-014 Write and read pointers SHALL be log2(DEPTH)+1 bits wide, binary plus Gray copies, and SHALL wrap modulo 2*DEPTH.
REQ-015 Write accepted iff i_wr=1 and o_full=0 at a s_clk rising edge; data stored and write pointer incremented on that edge.
REQ-016 i_wr=1 while o_full=1: write SHALL be ignored, with no pointer or memory change.
REQ-017 Read accepted iff i_rd=1 and o_empty=0 at an i_aclk rising edge; read pointer incremented on that edge, and o_rd_data SHALL show the next entry after that edge.
REQ-018 i_rd=1 while o_empty=1: ignored.
REQ-019 Gray pointers SHALL cross domains only through 2-flop synchronizers; no binary pointer SHALL cross.
REQ-020 o_full SHALL be registered and SHALL assert on the s_clk edge accepting the DEPTH-th outstanding word, i.e. with no added latency on the write side.
REQ-021 o_full SHALL deassert no earlier than 2 and no later than 3 s_clk edges after the freeing read pointer update (pessimistic).
REQ-022 o_empty SHALL be registered and SHALL assert on the i_aclk edge of the read that pops the last entry.
REQ-023 After a write, o_empty SHALL deassert no earlier than 2 and no later than 3 i_aclk edges after the write pointer update.
REQ-024 Full test: Gray wptr equals synchronized Gray rptr with its two MSBs inverted.
REQ-025 Empty test: Gray rptr equals synchronized Gray wptr.
REQ-026 Simultaneous write-at-full-minus-one and read: each side SHALL act only on its own domain view, with no loss, duplication or reordering of words.
REQ-027 Throughput: one write per s_clk and one read per i_aclk SHALL be sustainable when neither full nor empty.

Reset
REQ-028 s_rst low SHALL asynchronously clear both pointers, all synchronizer flops, o_full=0, o_empty=1, o_fill=0; o_rd_data is don't-care while o_empty=1.
REQ-029 s_rst deassertion SHALL be synchronized into i_aclk by a 2-flop synchronizer (asynchronous assert, synchronous release); the read side SHALL stay in reset until that release.
REQ-030 Reset mid-operation SHALL discard all contents; the first write after release is the first word read.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 Macro OUTFIFO_ASYNC_FILL_EN defined: o_fill SHALL be registered and equal to write pointer minus synchronized read pointer (modulo 2*DEPTH), range 0..DEPTH.
REQ-033 Macro OUTFIFO_ASYNC_FILL_EN undefined: o_fill port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package outfifo_async_pkg SHALL hold the pointer-width function (clog2+1) and the bin2gray/gray2bin functions.
REQ-035 Sub-module outfifo_gray_sync SHALL implement the parameterized-width 2-flop synchronizer and SHALL be used for both pointer crossings and for the reset release.

Verification (DEPTH=16, s_clk 100 MHz, i_aclk 250 MHz and 40 MHz runs)
REQ-036 Reset: s_rst low mid-stream -> o_empty=1, o_full=0, o_fill=0 immediately; after release, write 8'h5A -> 8'h5A is read first.
REQ-037 Fill: 16 back-to-back writes 8'h00..8'h0F with no reads -> o_full=1 on the edge of the 16th write; a 17th write of 8'hFF is dropped; reads return 8'h00..8'h0F, then o_empty=1.
REQ-038 Latency: one write of 8'hA5 into an empty FIFO -> o_empty falls on the 2nd or 3rd i_aclk edge after the write edge, with o_rd_data=8'hA5.
REQ-039 Streaming: 1000 incrementing words with random i_wr and i_rd gaps -> the read sequence exactly matches the write sequence, including pointer wrap at 32.
REQ-040 Boundary reads: i_rd held high while empty -> no pointer change; a scoreboard confirms no duplicated word when data arrives.
REQ-041 With OUTFIFO_ASYNC_FILL_EN: 5 writes, no reads -> o_fill=5; after 2 reads and 3 s_clk edges -> o_fill=3.
